// File: rtl/sha_mem_arbiter_if.sv
// Shared-memory arbiter bus: hash-core request side plus the single memory port.
interface sha_mem_arbiter_if #(
  parameter int unsigned NREQ = 2
);
  localparam int unsigned OW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Requester side
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    req_we;
  logic [16*NREQ-1:0] req_addr;
  logic [32*NREQ-1:0] req_wdata;
  logic [NREQ-1:0]    gnt;
  logic [31:0]        req_rdata;

  // Memory side
  logic               mem_clk;
  logic               mem_we;
  logic [15:0]        mem_addr;
  logic [31:0]        mem_write_data;
  logic [31:0]        mem_read_data;

  // Status
  logic               timeout_err;
  logic [OW-1:0]      owner;

  modport slave (
    input  req, req_we, req_addr, req_wdata, mem_read_data,
    output gnt, req_rdata, mem_clk, mem_we, mem_addr, mem_write_data,
           timeout_err, owner
  );

  modport master (
    output req, req_we, req_addr, req_wdata, mem_read_data,
    input  gnt, req_rdata, mem_clk, mem_we, mem_addr, mem_write_data,
           timeout_err, owner
  );
endinterface

// File: rtl/sha_mem_arbiter.sv
// Round-robin arbiter giving NREQ hash cores turns on one memory port,
// with no preemption, a forced release after MAX_HOLD granted cycles,
// and a mandatory idle cycle between consecutive grants.
module sha_mem_arbiter #(
  parameter int unsigned NREQ     = 2,
  parameter int unsigned MAX_HOLD = 4096
) (
  input  logic             clk,
  input  logic             reset_n,
  sha_mem_arbiter_if.slave bus
);
  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned HW = 16;
  localparam logic [HW-1:0]   HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [NREQ-1:0] GNT_ONE   = NREQ'(1);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t          r_state;
  logic [NREQ-1:0] r_gnt;
  logic [IW-1:0]   r_owner;
  logic [IW-1:0]   r_rr_ptr;
  logic [HW-1:0]   r_hold_cnt;
  logic            r_timeout_err;
  logic            r_armed;

  logic            w_found;
  logic [IW-1:0]   w_pick;
  logic [IW-1:0]   w_idx;
  logic            w_owner_req;

  // Round-robin successor of an index.
  function automatic logic [IW-1:0] f_next(input logic [IW-1:0] i);
    if (32'(i) == NREQ - 1) return '0;
    else                    return i + IW'(1);
  endfunction

  // First requester found searching upward from the round-robin pointer.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = IW'((32'(r_rr_ptr) + 32'(k)) % NREQ);
      if (!w_found && bus.req[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  assign w_owner_req = bus.req[r_owner];

  // Arbitration FSM; the first req-active edge after reset only arms it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_gnt         <= '0;
      r_owner       <= '0;
      r_rr_ptr      <= '0;
      r_hold_cnt    <= '0;
      r_timeout_err <= 1'b0;
      r_armed       <= 1'b0;
    end else begin
      r_armed <= r_armed | (|bus.req);
      case (r_state)
        S_IDLE: begin
          if (r_armed && w_found) begin
            r_state    <= S_GRANT;
            r_gnt      <= GNT_ONE << w_pick;
            r_owner    <= w_pick;
            r_rr_ptr   <= f_next(w_pick);
            r_hold_cnt <= '0;
          end
        end
        S_GRANT: begin
          if (!w_owner_req) begin
            r_state <= S_IDLE;
            r_gnt   <= '0;
            r_owner <= '0;
          end else if (r_hold_cnt == HOLD_LAST) begin
            r_state       <= S_IDLE;
            r_gnt         <= '0;
            r_owner       <= '0;
            r_timeout_err <= 1'b1;
            r_rr_ptr      <= f_next(r_owner);
          end else begin
            r_hold_cnt <= r_hold_cnt + HW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_gnt   <= '0;
          r_owner <= '0;
        end
      endcase
    end
  end

  // Memory port follows the owner only while it is still requesting.
  always_comb begin
    bus.mem_we         = 1'b0;
    bus.mem_addr       = '0;
    bus.mem_write_data = '0;
    if (r_state == S_GRANT && w_owner_req) begin
      bus.mem_we         = bus.req_we[r_owner];
      bus.mem_addr       = bus.req_addr[32'(r_owner)*16 +: 16];
      bus.mem_write_data = bus.req_wdata[32'(r_owner)*32 +: 32];
    end
  end

  assign bus.gnt         = r_gnt;
  assign bus.owner       = r_owner;
  assign bus.timeout_err = r_timeout_err;
  assign bus.req_rdata   = bus.mem_read_data;
  assign bus.mem_clk     = clk;
endmodule

// File: tb/tb_sha_mem_arbiter.sv
// Directed bench for sha_mem_arbiter with NREQ=2, MAX_HOLD=8.
module tb_sha_mem_arbiter;
  logic clk;
  logic reset_n;
  int   n_vec;
  int   n_err;

  sha_mem_arbiter_if #(.NREQ(2)) bus ();

  sha_mem_arbiter #(.NREQ(2), .MAX_HOLD(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset_n           = 1'b0;
    bus.req           = 2'b00;
    bus.req_we        = 2'b00;
    bus.req_addr      = '0;
    bus.req_wdata     = '0;
    bus.mem_read_data = '0;

    // Reset state
    #2;
    chk("rst_gnt", 64'(bus.gnt), 64'h0);
    chk("rst_owner", 64'(bus.owner), 64'h0);
    chk("rst_timeout", 64'(bus.timeout_err), 64'h0);
    chk("rst_mem_we", 64'(bus.mem_we), 64'h0);
    chk("rst_mem_addr", 64'(bus.mem_addr), 64'h0);
    chk("rst_mem_wdata", 64'(bus.mem_write_data), 64'h0);
    repeat (2) tick();
    reset_n = 1'b1;

    // Single request: first req edge only arms, second grants
    bus.req       = 2'b01;
    bus.req_we    = 2'b01;
    bus.req_addr  = {16'h0040, 16'h1234};
    bus.req_wdata = {32'hDEAD0002, 32'hCAFE0001};
    tick();
    chk("arm_gnt", 64'(bus.gnt), 64'h0);
    chk("arm_mem_we", 64'(bus.mem_we), 64'h0);
    tick();
    chk("single_gnt", 64'(bus.gnt), 64'h1);
    chk("single_owner", 64'(bus.owner), 64'h0);
    chk("single_addr", 64'(bus.mem_addr), 64'h1234);
    chk("single_we", 64'(bus.mem_we), 64'h1);
    chk("single_wdata", 64'(bus.mem_write_data), 64'hCAFE0001);
    bus.mem_read_data = 32'hA5A5_5A5A;
    #1;
    chk("rdata_bcast", 64'(bus.req_rdata), 64'hA5A55A5A);
    chk("mem_clk", 64'(bus.mem_clk), 64'(clk));
    repeat (3) tick();
    chk("single_hold", 64'(bus.gnt), 64'h1);
    bus.req = 2'b00;
    #1;
    chk("single_gate_we", 64'(bus.mem_we), 64'h0);
    chk("single_gate_addr", 64'(bus.mem_addr), 64'h0);
    tick();
    chk("single_drop", 64'(bus.gnt), 64'h0);

    // Simultaneous request from a fresh reset, with write isolation
    reset_n = 1'b0;
    #2;
    reset_n       = 1'b1;
    bus.req       = 2'b11;
    bus.req_we    = 2'b10;
    bus.req_addr  = {16'h0040, 16'h0100};
    bus.req_wdata = {32'h1111_1111, 32'h2222_2222};
    tick();
    chk("sim_arm", 64'(bus.gnt), 64'h0);
    tick();
    chk("sim_gnt0", 64'(bus.gnt), 64'h1);
    chk("iso_addr", 64'(bus.mem_addr), 64'h0100);
    chk("iso_we", 64'(bus.mem_we), 64'h0);
    chk("iso_wdata", 64'(bus.mem_write_data), 64'h22222222);
    tick();
    chk("sim_no_preempt", 64'(bus.gnt), 64'h1);
    bus.req = 2'b10;
    tick();
    chk("sim_turnaround", 64'(bus.gnt), 64'h0);
    bus.req = 2'b11;
    tick();
    chk("sim_gnt1", 64'(bus.gnt), 64'h2);
    chk("sim_owner1", 64'(bus.owner), 64'h1);
    chk("sim_addr1", 64'(bus.mem_addr), 64'h0040);
    chk("sim_we1", 64'(bus.mem_we), 64'h1);
    tick();
    chk("sim_hold1", 64'(bus.gnt), 64'h2);
    bus.req = 2'b01;
    tick();
    chk("sim_turn2", 64'(bus.gnt), 64'h0);
    tick();
    chk("sim_back0", 64'(bus.gnt), 64'h1);
    bus.req = 2'b00;
    tick();
    chk("sim_idle", 64'(bus.gnt), 64'h0);

    // Timeout: core 0 keeps requesting, core 1 waits
    bus.req = 2'b01;
    tick();
    chk("to_gnt0", 64'(bus.gnt), 64'h1);
    bus.req = 2'b11;
    for (int i = 1; i < 8; i++) begin
      tick();
      chk("to_held", 64'(bus.gnt), 64'h1);
      chk("to_err_low", 64'(bus.timeout_err), 64'h0);
    end
    tick();
    chk("to_release", 64'(bus.gnt), 64'h0);
    chk("to_err_set", 64'(bus.timeout_err), 64'h1);
    tick();
    chk("to_next_core1", 64'(bus.gnt), 64'h2);
    repeat (3) tick();
    chk("to_sticky", 64'(bus.timeout_err), 64'h1);
    chk("to_core1_we", 64'(bus.mem_we), 64'h1);

    // Reset mid-grant drops outputs without a clock edge
    reset_n = 1'b0;
    #1;
    chk("mid_rst_gnt", 64'(bus.gnt), 64'h0);
    chk("mid_rst_we", 64'(bus.mem_we), 64'h0);
    chk("mid_rst_err", 64'(bus.timeout_err), 64'h0);
    #3;
    reset_n = 1'b1;
    bus.req = 2'b11;
    tick();
    chk("post_rst_arm", 64'(bus.gnt), 64'h0);
    tick();
    chk("post_rst_gnt0", 64'(bus.gnt), 64'h1);
    chk("post_rst_owner", 64'(bus.owner), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/sha_mem_arbiter.md
SHA_MEM_ARBITER -- requirements
Module: sha_mem_arbiter

Interface
REQ-001 Parameter NREQ, default 2, meaning number of hash-core requesters sharing one memory port (legal range 2..8).
REQ-002 Parameter MAX_HOLD, default 4096, meaning maximum consecutive granted cycles before forced release (legal range 2..65535).
REQ-003 Port clk  input  1  the single clock for all state; reset is asynchronous and active-low.
REQ-004 Port reset_n  input  1  asynchronous active-low reset.
REQ-005 Port req  input  NREQ  per-requester memory request, bit i = core i.
REQ-006 Port req_we  input  NREQ  per-requester write enable.
REQ-007 Port req_addr  input  16*NREQ  per-requester address; slice [16i+15:16i] = core i.
REQ-008 Port req_wdata  input  32*NREQ  per-requester write data; slice [32i+31:32i] = core i.
REQ-009 Port gnt  output  NREQ  one-hot-or-zero grant, registered.
REQ-010 Port req_rdata  output  32  mem_read_data broadcast to all requesters, unregistered.
REQ-011 Port mem_clk  output  1  equal to clk.
REQ-012 Port mem_we, mem_addr, mem_write_data  output  1/16/32  shared memory port.
REQ-013 Port mem_read_data  input  32  shared memory read data.
REQ-014 Port timeout_err  output  1  sticky flag, forced release occurred.
REQ-015 Port owner  output  $clog2(NREQ)  index of current grantee, 0 when idle.

Function
REQ-016 The block SHALL implement two states: IDLE (no grant) and GRANT (exactly one gnt bit high).
REQ-017 In IDLE with any req bit high at edge N, the block SHALL enter GRANT with gnt one-hot at cycle N+1 (one-cycle grant latency).
REQ-018 Selection SHALL be round-robin: the first requesting index found searching upward from rr_ptr, modulo NREQ.
REQ-019 On each grant to index i, rr_ptr SHALL be set to (i+1) mod NREQ.
REQ-020 In GRANT, while req[owner]=1 and hold_cnt < MAX_HOLD-1, the grant SHALL be held regardless of other requests (no preemption).
REQ-021 In GRANT, when req[owner]=0, the block SHALL return to IDLE, dropping gnt the next cycle.
REQ-022 There SHALL be at least one cycle with gnt=0 between any two grants (bus turnaround), including when the same requester re-requests.
REQ-023 hold_cnt (16 bits) SHALL clear on entering GRANT and increment each GRANT cycle.
REQ-024 In GRANT, when hold_cnt reaches MAX_HOLD-1 with req[owner] still 1, the block SHALL return to IDLE, set timeout_err, and advance rr_ptr as in REQ-019.
REQ-025 When gnt is zero, the block SHALL drive mem_we=0, mem_addr=0 and mem_write_data=0.
REQ-026 In GRANT, mem_we, mem_addr and mem_write_data SHALL combinationally equal the owner's req_we, req_addr and req_wdata slices, gated by req[owner].
REQ-027 A mem_we from a non-granted requester SHALL never reach the memory port.
REQ-028 req_rdata SHALL equal mem_read_data at all times; consumers qualify it with their own gnt and their one-cycle read latency.
REQ-029 timeout_err SHALL remain set until reset.
REQ-030 owner SHALL equal the index of the set gnt bit in GRANT, and 0 in IDLE.

Reset
REQ-031 On reset_n low, asynchronously: state=IDLE, gnt=0, rr_ptr=0, hold_cnt=0, timeout_err=0, owner=0; mem_we, mem_addr and mem_write_data are therefore 0.
REQ-032 Reset asserted mid-grant SHALL drop gnt immediately without waiting for a clock edge.
REQ-033 After reset_n rises, the first eligible grant SHALL occur at the second rising edge at which req is nonzero.

Verification (NREQ=2, MAX_HOLD=8)
REQ-034 Single request: req=01 at cycle 0 -> gnt=01 at cycle 1; mem_addr equals req_addr[15:0]; drop req at cycle 5 -> gnt=00 at cycle 6.
REQ-035 Simultaneous request: req=11 from reset -> gnt=01, then after core 0 releases, one idle cycle, then gnt=10; core 0 re-requesting while held -> core 1 still served first.
REQ-036 Write isolation: core 1 drives req_we=1 with addr 16'h0040 while core 0 is granted -> mem_we follows core 0 only; mem_addr is never 16'h0040.
REQ-037 Timeout: core 0 holds req=1 for 20 cycles -> gnt drops after 8 granted cycles, timeout_err=1 and sticky; core 1 is then granted if requesting.
REQ-038 Reset mid-grant: reset_n low while gnt=10 -> gnt=00 and mem_we=0 asynchronously; after release, req=11 -> core 0 granted first.
